spi_rx_stream: RTL and testbench

Parametrised serial-to-stream receiver: deserialises 1..N-lane SPI-like frames clocked by an external `sclk`, moves each completed word into the `aclk` domain through a toggle-synchroniser handshake, and buffers words in a DEPTH-entry FIFO drained over an AXI4-Stream master port. It sits between the ASIC serial output pins and the DMA/stream interconnect. It replaces the single-lane, unbuffered receiver, adding lanes, bit order, gap resync, back-pressure buffering and overflow accounting.

---
 rtl/spi_rx_stream.sv | 141 ++++++++++++++
 tb/tb_spi_rx_stream.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_stream.sv
// Serial-to-stream receiver: multi-lane sclk-domain deserialiser, toggle handshake into aclk,
// and a first-word-fall-through FIFO drained over an AXI4-Stream master port.
module spi_rx_stream #(
    parameter int PACKET_LENGTH = 32,
    parameter int LANES         = 1,
    parameter int DEPTH         = 8,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit GAP_RESET     = 1'b1
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       sclk,
    input  logic [LANES-1:0]           sdata,
    input  logic                       svalid,
    output logic [PACKET_LENGTH-1:0]   m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    input  logic                       ovf_clr,
    output logic [$clog2(DEPTH):0]     fill_level
);

    localparam int BEATS = PACKET_LENGTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;

    // ---------------- sclk domain ----------------
    logic [BW-1:0]            beat_q, beat_d;
    logic [PACKET_LENGTH-1:0] shift_q, shift_d, hold_q, hold_d, shifted;
    logic                     rx_toggle_q, rx_toggle_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        beat_d      = beat_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        rx_toggle_d = rx_toggle_q;
        if (MSB_FIRST) begin
            shifted = {shift_q[PACKET_LENGTH-LANES-1:0], sdata};
        end else begin
            shifted = {sdata, shift_q[PACKET_LENGTH-1:LANES]};
        end
        if (svalid) begin
            shift_d = shifted;
            if (beat_q == BW'(BEATS - 1)) begin
                hold_d      = shifted;
                beat_d      = '0;
                rx_toggle_d = ~rx_toggle_q;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end else if (GAP_RESET) begin
            beat_d  = '0;
            shift_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous active-low.
    always_ff @(negedge sclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_q      <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            rx_toggle_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            rx_toggle_q <= rx_toggle_d;
        end
    end

    // ---------------- aclk domain ----------------
    logic          sync1_q, sync2_q, hist_q;
    logic          word_arrive;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          full, empty, push, pop, drop;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic [PACKET_LENGTH-1:0] mem_q [DEPTH];

    // hold_q is only sampled here on word_arrive, long after it settled in the sclk domain.
    assign word_arrive = sync2_q ^ hist_q;
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = !empty && m_tready;
    assign push  = word_arrive && (!full || pop);
    assign drop  = word_arrive && !push;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d   = 1'b1;
            drop_count_d = ovf_clr ? 16'd1
                         : (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;
        end else if (ovf_clr) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    // NOTE: sync1_q is the only flop allowed to go metastable; nothing else reads it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            sync1_q      <= rx_toggle_q;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag masks stale entries on the output.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= hold_q;
        end
    end

    assign m_tdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign m_tvalid   = !empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign fill_level = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_spi_rx_stream.sv
// Scoreboard bench for spi_rx_stream: default instance (1 lane, MSB-first, gap reset) plus a
// 4-lane LSB-first instance that holds partial words across gaps.
module tb_spi_rx_stream;

    localparam int TS = 7;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic        sclk = 1'b0, svalid = 1'b0, m_tready = 1'b0, ovf_clr = 1'b0;
    logic [0:0]  sdata = '0;
    logic [31:0] m_tdata;
    logic        m_tvalid, overflow;
    logic [15:0] drop_count;
    logic [3:0]  fill_level;

    logic        sclk2 = 1'b0, svalid2 = 1'b0, tready2 = 1'b1, ovf_clr2 = 1'b0;
    logic [3:0]  sdata2 = '0;
    logic [31:0] m_tdata2;
    logic        m_tvalid2, overflow2;
    logic [15:0] drop_count2;
    logic [3:0]  fill_level2;

    int          n_vec = 0, n_fail = 0;
    logic [31:0] q[$], q2[$];
    bit          rand_ready = 1'b0;

    spi_rx_stream u_dut (
        .aclk(aclk), .aresetn(aresetn), .sclk(sclk), .sdata(sdata), .svalid(svalid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .overflow(overflow),
        .drop_count(drop_count), .ovf_clr(ovf_clr), .fill_level(fill_level)
    );

    spi_rx_stream #(.LANES(4), .MSB_FIRST(1'b0), .GAP_RESET(1'b0)) u_lsb (
        .aclk(aclk), .aresetn(aresetn), .sclk(sclk2), .sdata(sdata2), .svalid(svalid2),
        .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(tready2), .overflow(overflow2),
        .drop_count(drop_count2), .ovf_clr(ovf_clr2), .fill_level(fill_level2)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic d, input logic v);
        sclk = 1'b1; sdata = d; svalid = v;
        #TS sclk = 1'b0;
        #TS;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int k = 0; k < n; k++) send_beat(w[31-k], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_bits(w, 32);
        svalid = 1'b0;
    endtask

    task automatic send_beat2(input logic [3:0] d, input logic v);
        sclk2 = 1'b1; sdata2 = d; svalid2 = v;
        #TS sclk2 = 1'b0;
        #TS;
    endtask

    task automatic send_nibbles2(input logic [31:0] w, input int first, input int n);
        for (int k = first; k < first + n; k++) send_beat2(w[4*k +: 4], 1'b1);
        svalid2 = 1'b0;
    endtask

    // Changes m_tready just after a rising edge so the negedge monitor never races it.
    task automatic set_ready(input logic v);
        @(posedge aclk);
        #2 m_tready = v;
    endtask

    task automatic wait_arrive(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge aclk);
            #1;
            if (u_dut.word_arrive) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (q.size() == 0 && fill_level == 4'd0) break;
            @(negedge aclk);
        end
        check({name, "_queue_left"}, 32'(q.size()), 32'd0);
        check({name, "_fill"}, 32'(fill_level), 32'd0);
    endtask

    // Monitor: pops on every accepted beat and checks AXI-S stability while stalled.
    initial begin : monitor
        bit          prev_stall;
        logic [31:0] prev_data, exp;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(m_tvalid), 32'd1);
                    check("stall_data", m_tdata, prev_data);
                end
                if (m_tvalid && m_tready) begin
                    if (q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL unexpected_word: got %h expected none", m_tdata);
                    end else begin
                        exp = q.pop_front();
                        check("word", m_tdata, exp);
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
            end
        end
    end

    initial begin : monitor2
        logic [31:0] exp;
        forever begin
            @(negedge aclk);
            if (aresetn && m_tvalid2 && tready2) begin
                if (q2.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL lsb_unexpected_word: got %h expected none", m_tdata2);
                end else begin
                    exp = q2.pop_front();
                    check("lsb_word", m_tdata2, exp);
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge aclk);
            #1;
            if (rand_ready) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #3_000_000;
        n_vec++; n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : stimulus
        int n;
        bit seen;
        repeat (3) @(negedge aclk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_lsb_tvalid", 32'(m_tvalid2), 32'd0);
        @(negedge aclk) aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Basic MSB-first word, valid for exactly one cycle with ready held high.
        set_ready(1'b1);
        q.push_back(32'hDEADBEEF);
        send_word(32'hDEADBEEF);
        n = 0;
        repeat (20) begin
            @(negedge aclk);
            if (m_tvalid) n++;
        end
        check("basic_valid_cycles", 32'(n), 32'd1);
        wait_drain("basic");

        // Gap resync: 10 stray bits, one idle beat, then a full frame.
        q.push_back(32'hA5A5A5A5);
        send_bits(32'h3C3C3C3C, 10);
        send_beat(1'b0, 1'b0);
        send_word(32'hA5A5A5A5);
        wait_drain("gap");

        // 4-lane LSB-first, then a partial word held across a gap.
        q2.push_back(32'h12345678);
        send_nibbles2(32'h12345678, 0, 8);
        q2.push_back(32'h9ABCDEF0);
        send_nibbles2(32'h9ABCDEF0, 0, 3);
        send_beat2(4'hF, 1'b0);
        send_nibbles2(32'h9ABCDEF0, 3, 5);
        for (int i = 0; i < 300; i++) begin
            if (q2.size() == 0) break;
            @(negedge aclk);
        end
        check("lsb_queue_left", 32'(q2.size()), 32'd0);

        // Overflow: ten words into an eight-entry FIFO with no ready.
        set_ready(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) q.push_back(32'(i));
            send_word(32'(i));
        end
        repeat (10) @(negedge aclk);
        check("ovf_fill", 32'(fill_level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drop_count", 32'(drop_count), 32'd2);

        // Clear on the same edge as a drop: the drop wins.
        fork
            send_word(32'd10);
            begin
                wait_arrive(seen);
                ovf_clr = 1'b1;
                @(posedge aclk);
                #1 ovf_clr = 1'b0;
            end
        join
        check("race_arrive_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge aclk);
        check("race_flag", 32'(overflow), 32'd1);
        check("race_drop_count", 32'(drop_count), 32'd1);
        @(negedge aclk) ovf_clr = 1'b1;
        @(posedge aclk);
        #1 ovf_clr = 1'b0;
        @(negedge aclk);
        check("clr_flag", 32'(overflow), 32'd0);
        check("clr_drop_count", 32'(drop_count), 32'd0);

        // Full FIFO with a pop on the arrival edge: write accepted, level stays at DEPTH.
        q.push_back(32'd11);
        fork
            send_word(32'd11);
            begin
                wait_arrive(seen);
                m_tready = 1'b1;
                @(posedge aclk);
                #1 m_tready = 1'b0;
            end
        join
        check("fullpop_arrive_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge aclk);
        check("fullpop_fill", 32'(fill_level), 32'd8);
        check("fullpop_flag", 32'(overflow), 32'd0);
        check("fullpop_drop_count", 32'(drop_count), 32'd0);
        set_ready(1'b1);
        wait_drain("ovf");

        // Random back-pressure over 100 sequence-numbered words (wraps the pointers).
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            q.push_back(32'(i + 256));
            send_word(32'(i + 256));
        end
        @(posedge aclk);
        #2 rand_ready = 1'b0;
        m_tready = 1'b1;
        wait_drain("random");
        check("random_drop_count", 32'(drop_count), 32'd0);

        // Reset mid-frame with buffered words; next frame must arrive intact.
        set_ready(1'b0);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_bits(32'h33333333, 15);
        repeat (5) @(negedge aclk);
        check("prerst_fill", 32'(fill_level), 32'd2);
        aresetn = 1'b0;
        #3;
        check("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_tdata", m_tdata, 32'd0);
        check("midrst_fill", 32'(fill_level), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        set_ready(1'b1);
        q.push_back(32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        wait_drain("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
